qdi_rx_sync_sink: RTL and testbench

//  Clocked consumer that sits directly downstream of the e1of4 QDI-to-binary receiver (rxe-enabled variant).

---
 rtl/qdi_rx_sync_sink.sv | 150 +++++++++++++++
 tb/tb_qdi_rx_sync_sink.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qdi_rx_sync_sink.sv
// qdi_rx_sync_sink: clocked consumer behind the e1of4 QDI-to-binary receiver.
// Synchronises valid/dout, runs the rxe 4-phase handshake, packs 2-bit digits
// LSB-first into words, buffers them in a first-word-fall-through FIFO and
// keeps saturating token / stall counters plus a sticky ACCEPT timeout flag.
module qdi_rx_sync_sink #(
    parameter int WORD_W  = 8,
    parameter int DEPTH   = 4,
    parameter int SYNC    = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              en,
    input  logic [1:0]        dout_in,
    input  logic              valid_in,
    output logic              rxe,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       tok_cnt,
    output logic [31:0]       stall_cnt,
    output logic              timeout_err
);

    localparam int NDIG = WORD_W / 2;
    localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = AW + 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(NDIG - 1);
    localparam logic [31:0]   TMO_LAST = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);

    typedef enum logic {IDLE, ACCEPT} state_t;

    state_t                 state;
    logic [SYNC-1:0]        vsync;
    logic [SYNC-1:0][1:0]   dsync;
    logic                   valid_s;
    logic [1:0]             din_s;
    logic [IW-1:0]          idx;
    logic [WORD_W-1:0]      part;
    logic [WORD_W-1:0]      push_word;
    logic [31:0]            tmo_cnt;
    logic [WORD_W-1:0]      mem [DEPTH];
    logic [AW-1:0]          wptr, rptr;
    logic [CW-1:0]          fifo_cnt;
    logic                   fifo_full, capture, push, pop;

    // Equal-length synchronisers so din_s is aligned with valid_s
    always_ff @(posedge CLK) begin
        if (RESET) begin
            vsync <= '0;
            dsync <= '0;
        end else begin
            vsync <= {vsync[SYNC-2:0], valid_in};
            dsync <= {dsync[SYNC-2:0], dout_in};
        end
    end

    assign valid_s   = vsync[SYNC-1];
    assign din_s     = dsync[SYNC-1];
    assign fifo_full = (fifo_cnt == CW'(DEPTH));
    assign capture   = (state == ACCEPT) && !valid_s;
    assign push      = capture && (idx == IDX_LAST);
    assign out_valid = (fifo_cnt != '0);
    assign pop       = out_valid && out_ready;
    assign out_data  = out_valid ? mem[rptr] : '0;

    // Word being completed: partial word with the current digit dropped into its slot
    always_comb begin
        push_word = part;
        push_word[2*idx +: 2] = din_s;
    end

    // Handshake FSM, digit packing, counters and timeout flag
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= IDLE;
            rxe         <= 1'b0;
            idx         <= '0;
            part        <= '0;
            tok_cnt     <= '0;
            stall_cnt   <= '0;
            tmo_cnt     <= '0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // Free space is only checked here; one ACCEPT pushes at most one word
                    if (valid_s && en && !fifo_full) begin
                        state   <= ACCEPT;
                        rxe     <= 1'b1;
                        tmo_cnt <= '0;
                    end else if (valid_s && stall_cnt != '1) begin
                        stall_cnt <= stall_cnt + 32'd1;
                    end
                end
                ACCEPT: begin
                    if (tmo_cnt != '1)
                        tmo_cnt <= tmo_cnt + 32'd1;
                    if (TIMEOUT != 0 && tmo_cnt == TMO_LAST)
                        timeout_err <= 1'b1;
                    // valid_s low means the receiver has latched dout and gone neutral
                    if (!valid_s) begin
                        state <= IDLE;
                        rxe   <= 1'b0;
                        if (tok_cnt != '1)
                            tok_cnt <= tok_cnt + 32'd1;
                        if (push) begin
                            idx  <= '0;
                            part <= '0;
                        end else begin
                            idx  <= idx + 1'b1;
                            part <= push_word;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    rxe   <= 1'b0;
                end
            endcase
        end
    end

    // FIFO storage; contents are don't-care until written, pointers carry the state
    always_ff @(posedge CLK) begin
        if (push)
            mem[wptr] <= push_word;
    end

    // FIFO pointers and occupancy; push and pop together leave the count unchanged
    always_ff @(posedge CLK) begin
        if (RESET) begin
            wptr     <= '0;
            rptr     <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_qdi_rx_sync_sink.sv
// Directed bench for qdi_rx_sync_sink with a 4-phase receiver model and a
// word scoreboard for the random traffic run.
module tb_qdi_rx_sync_sink;

    localparam int WORD_W  = 8;
    localparam int DEPTH   = 4;
    localparam int SYNC    = 2;
    localparam int TIMEOUT = 16;

    logic              CLK = 1'b0;
    logic              RESET = 1'b1;
    logic              en = 1'b0;
    logic [1:0]        dout_in = 2'b00;
    logic              valid_in = 1'b0;
    logic              out_ready = 1'b0;
    logic              rxe;
    logic [WORD_W-1:0] out_data;
    logic              out_valid;
    logic [31:0]       tok_cnt;
    logic [31:0]       stall_cnt;
    logic              timeout_err;

    int total = 0;
    int bad   = 0;

    qdi_rx_sync_sink #(.WORD_W(WORD_W), .DEPTH(DEPTH), .SYNC(SYNC), .TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .RESET(RESET), .en(en), .dout_in(dout_in), .valid_in(valid_in),
        .rxe(rxe), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .tok_cnt(tok_cnt), .stall_cnt(stall_cnt), .timeout_err(timeout_err)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic wait_rxe(input logic v, input string tag);
        int k = 0;
        while (rxe !== v && k < 3000) begin
            @(negedge CLK);
            k++;
        end
        total++;
        if (rxe !== v) begin
            bad++;
            $display("FAIL %s: rxe=%b want %b (timed out)", tag, rxe, v);
        end
    endtask

    // Receiver model: raise valid with data, wait for rxe, go neutral, wait rxe low
    task automatic send_digit(input logic [1:0] d);
        dout_in  = d;
        valid_in = 1'b1;
        wait_rxe(1'b1, "rxe_rise");
        valid_in = 1'b0;
        wait_rxe(1'b0, "rxe_fall");
    endtask

    task automatic send_word(input logic [7:0] w);
        for (int k = 0; k < 4; k++) send_digit(w[2*k +: 2]);
    endtask

    task automatic pop_check(input logic [7:0] exp, input string tag);
        total++;
        if (out_valid !== 1'b1 || out_data !== exp) begin
            bad++;
            $display("FAIL %s: out_valid=%b out_data=%h want 1/%h", tag, out_valid, out_data, exp);
        end
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        tick(2);
        RESET = 1'b0;
        total++;
        if ({rxe, out_valid, out_data, tok_cnt, stall_cnt, timeout_err} !== '0) begin
            bad++;
            $display("FAIL reset_state: rxe=%b ov=%b od=%h tok=%0d stall=%0d err=%b want all 0",
                     rxe, out_valid, out_data, tok_cnt, stall_cnt, timeout_err);
        end
    endtask

    // Digits 01,10,11,00 packed LSB-first: {00,11,10,01} = 8'h39
    task automatic test_pack();
        en = 1'b1;
        dout_in  = 2'b01;
        valid_in = 1'b1;
        tick(SYNC);
        total++;
        if (rxe !== 1'b0) begin bad++; $display("FAIL rxe_early: rxe=%b want 0", rxe); end
        tick(1);
        total++;
        if (rxe !== 1'b1) begin bad++; $display("FAIL rxe_latency: rxe=%b want 1", rxe); end
        valid_in = 1'b0;
        wait_rxe(1'b0, "rxe_fall");
        send_digit(2'b10);
        send_digit(2'b11);
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL partial_word: out_valid=%b want 0", out_valid); end
        send_digit(2'b00);
        total++;
        if (tok_cnt !== 32'd4) begin bad++; $display("FAIL pack_tok: tok_cnt=%0d want 4", tok_cnt); end
        pop_check(8'h39, "pack_word");
    endtask

    task automatic test_fifo_full();
        logic [7:0] ws [5];
        logic [31:0] s0;
        logic seen;
        ws[0] = 8'h1B; ws[1] = 8'hE4; ws[2] = 8'h72; ws[3] = 8'h9C; ws[4] = 8'h3F;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_word(ws[i]);
        s0 = stall_cnt;
        dout_in  = ws[4][1:0];
        valid_in = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            tick(1);
            if (rxe) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin bad++; $display("FAIL full_rxe: rxe rose=%b want 0", seen); end
        total++;
        if (stall_cnt - s0 !== 32'(20 - SYNC)) begin
            bad++;
            $display("FAIL full_stall: stall delta=%0d want %0d", stall_cnt - s0, 20 - SYNC);
        end
        pop_check(ws[0], "full_pop0");
        wait_rxe(1'b1, "full_resume");
        valid_in = 1'b0;
        wait_rxe(1'b0, "full_rxe_fall");
        for (int k = 1; k < 4; k++) send_digit(ws[4][2*k +: 2]);
        for (int i = 1; i < 5; i++) pop_check(ws[i], "full_drain");
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL full_empty: out_valid=%b want 0", out_valid); end
    endtask

    // Digits 10,11,01,00 -> 8'h1E
    task automatic test_en();
        logic [31:0] s0;
        logic seen;
        en = 1'b0;
        s0 = stall_cnt;
        dout_in  = 2'b10;
        valid_in = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            tick(1);
            if (rxe) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin bad++; $display("FAIL en_block: rxe rose=%b want 0", seen); end
        total++;
        if (stall_cnt - s0 !== 32'(20 - SYNC)) begin
            bad++;
            $display("FAIL en_stall: stall delta=%0d want %0d", stall_cnt - s0, 20 - SYNC);
        end
        en = 1'b1;
        tick(1);
        total++;
        if (rxe !== 1'b1) begin bad++; $display("FAIL en_release: rxe=%b want 1", rxe); end
        valid_in = 1'b0;
        wait_rxe(1'b0, "en_rxe_fall");
        send_digit(2'b11);
        send_digit(2'b01);
        send_digit(2'b00);
        pop_check(8'h1E, "en_word");
        total++;
        if (tok_cnt !== 32'd28) begin bad++; $display("FAIL en_tok: tok_cnt=%0d want 28", tok_cnt); end
    endtask

    task automatic test_timeout();
        dout_in  = 2'b01;
        valid_in = 1'b1;
        wait_rxe(1'b1, "tmo_enter");
        tick(15);
        total++;
        if (timeout_err !== 1'b0) begin bad++; $display("FAIL tmo_early: err=%b want 0", timeout_err); end
        tick(1);
        total++;
        if (timeout_err !== 1'b1) begin bad++; $display("FAIL tmo_set: err=%b want 1", timeout_err); end
        tick(30);
        total++;
        if (timeout_err !== 1'b1 || rxe !== 1'b1) begin
            bad++;
            $display("FAIL tmo_sticky: err=%b rxe=%b want 1/1", timeout_err, rxe);
        end
        RESET    = 1'b1;
        valid_in = 1'b0;
        tick(1);
        RESET = 1'b0;
        total++;
        if ({timeout_err, rxe, tok_cnt} !== '0) begin
            bad++;
            $display("FAIL tmo_reset: err=%b rxe=%b tok=%0d want 0/0/0", timeout_err, rxe, tok_cnt);
        end
    endtask

    // After reset the parked digit 01 becomes digit 0: {11,10,00,01} = 8'hE1
    task automatic test_reset_mid();
        tick(SYNC + 1);
        send_digit(2'b11);
        send_digit(2'b01);
        send_digit(2'b10);
        total++;
        if (tok_cnt !== 32'd3 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL mid_pre: tok=%0d ov=%b want 3/0", tok_cnt, out_valid);
        end
        dout_in  = 2'b01;
        valid_in = 1'b1;
        wait_rxe(1'b1, "mid_accept");
        RESET = 1'b1;
        tick(1);
        total++;
        if ({rxe, out_valid, out_data, tok_cnt} !== '0) begin
            bad++;
            $display("FAIL mid_reset: rxe=%b ov=%b od=%h tok=%0d want all 0", rxe, out_valid, out_data, tok_cnt);
        end
        RESET = 1'b0;
        wait_rxe(1'b1, "mid_reaccept");
        valid_in = 1'b0;
        wait_rxe(1'b0, "mid_rxe_fall");
        send_digit(2'b00);
        send_digit(2'b10);
        send_digit(2'b11);
        pop_check(8'hE1, "mid_word");
        total++;
        if (tok_cnt !== 32'd4) begin bad++; $display("FAIL mid_tok: tok_cnt=%0d want 4", tok_cnt); end
    endtask

    // Last digit of word 4 lands on the same edge word 1 is popped at fifo_cnt=3
    task automatic test_back_to_back();
        logic [7:0] bw [4];
        bw[0] = 8'h4C; bw[1] = 8'hD2; bw[2] = 8'h67; bw[3] = 8'hB9;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send_word(bw[i]);
        for (int k = 0; k < 3; k++) send_digit(bw[3][2*k +: 2]);
        dout_in  = bw[3][7:6];
        valid_in = 1'b1;
        wait_rxe(1'b1, "b2b_accept");
        valid_in = 1'b0;
        tick(SYNC);
        total++;
        if (out_valid !== 1'b1 || out_data !== bw[0] || rxe !== 1'b1) begin
            bad++;
            $display("FAIL b2b_head: ov=%b od=%h rxe=%b want 1/%h/1", out_valid, out_data, rxe, bw[0]);
        end
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        wait_rxe(1'b0, "b2b_capture");
        for (int i = 1; i < 4; i++) pop_check(bw[i], "b2b_drain");
        total++;
        if (out_valid !== 1'b0 || tok_cnt !== 32'd20) begin
            bad++;
            $display("FAIL b2b_end: ov=%b tok=%0d want 0/20", out_valid, tok_cnt);
        end
    endtask

    task automatic test_random();
        logic [7:0] exp_q [$];
        logic [7:0] cur;
        logic [7:0] exp;
        logic [1:0] dg;
        bit drv_done;
        bit slow;
        int got;
        cur = '0;
        drv_done = 1'b0;
        slow = 1'b1;
        got = 0;
        fork
            begin
                for (int i = 0; i < 256; i++) begin
                    dg = 2'($urandom_range(0, 3));
                    cur[2*(i%4) +: 2] = dg;
                    if (i % 4 == 3) exp_q.push_back(cur);
                    slow = (i < 128);
                    send_digit(dg);
                end
                drv_done = 1'b1;
            end
            begin
                int guard = 0;
                while (!(drv_done && exp_q.size() == 0) && guard < 30000) begin
                    @(negedge CLK);
                    guard++;
                    if (drv_done) out_ready = 1'b1;
                    else if (slow) out_ready = ($urandom_range(0, 63) == 0);
                    else out_ready = ($urandom_range(0, 1) == 0);
                    if (out_valid && out_ready) begin
                        total++;
                        got++;
                        if (exp_q.size() == 0) begin
                            bad++;
                            $display("FAIL rand_extra: unexpected word %h", out_data);
                        end else begin
                            exp = exp_q.pop_front();
                            if (out_data !== exp) begin
                                bad++;
                                $display("FAIL rand_word: out_data=%h want %h", out_data, exp);
                            end
                        end
                    end
                end
            end
        join
        tick(1);
        out_ready = 1'b0;
        tick(1);
        total++;
        if (got != 64 || exp_q.size() != 0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL rand_count: got=%0d left=%0d ov=%b want 64/0/0", got, exp_q.size(), out_valid);
        end
        total++;
        if (tok_cnt !== 32'd276) begin bad++; $display("FAIL rand_tok: tok_cnt=%0d want 276", tok_cnt); end
    endtask

    initial begin
        tick(1);
        test_reset();
        test_pack();
        test_fifo_full();
        test_en();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
